cmp_seq_wide: RTL

- Sequential wide-word magnitude comparator. Compares two DATA_W-bit unsigned operands one SLICE_W-bit slice per clock, MSB slice first.
- Carries a big/equal/small cascade state between slices, using the same cascade semantics as the 16-bit cascadable comparator.
- Sits upstream of that comparator. It produces one-hot cascade flags that can drive the comparator's fi_big/fi_equal/fi_small inputs, or feed any consumer of a wide compare result.
- Uses a start/busy/done handshake so a narrow datapath can compare 64-bit or wider keys.

---
 rtl/cmp_seq_wide.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cmp_seq_wide.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_seq_wide
//  Purpose  : Sequential wide-word unsigned magnitude comparator. Compares
//             two DATA_W-bit operands one SLICE_W-bit slice per clock, MSB
//             slice first. A one-hot big/equal/small cascade state is carried
//             from slice to slice, seeded from the cascade-in flags.
//  Ports    : clk, rst_n        - clock, synchronous active-low reset
//             start             - request pulse, accepted only while idle
//             a, b              - operands, latched on an accepted start
//             fi_big/equal/small- cascade-in from a more-significant stage
//             busy              - slices are being compared
//             done              - one-cycle pulse, result valid from here on
//             fo_big/equal/small- one-hot result, held until next finish
//  Revision : 1.0  initial release
// ============================================================================
module cmp_seq_wide #(
    parameter int DATA_W     = 64,
    parameter int SLICE_W    = 16,
    parameter int EARLY_EXIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              fi_big,
    input  logic              fi_equal,
    input  logic              fi_small,
    output logic              busy,
    output logic              done,
    output logic              fo_big,
    output logic              fo_equal,
    output logic              fo_small
);

    localparam int c_NSLICE = DATA_W / SLICE_W;
    localparam int c_IDX_W  = (c_NSLICE > 1) ? $clog2(c_NSLICE) : 1;

    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_NSLICE - 1);
    localparam logic [c_IDX_W-1:0] c_ONE  = c_IDX_W'(1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic               r_big;
    logic               r_eq;
    logic               r_small;
    logic               r_busy;
    logic               r_done;
    logic               r_fo_big;
    logic               r_fo_eq;
    logic               r_fo_small;

    // The operand registers shift left one slice per RUN edge, so the slice
    // under comparison is always the top SLICE_W bits.
    logic [SLICE_W-1:0] w_slice_a;
    logic [SLICE_W-1:0] w_slice_b;
    logic               w_nxt_big;
    logic               w_nxt_eq;
    logic               w_nxt_small;
    logic               w_finish;

    assign w_slice_a = r_a[DATA_W-1 -: SLICE_W];
    assign w_slice_b = r_b[DATA_W-1 -: SLICE_W];

    always_comb begin
        w_nxt_big   = r_big;
        w_nxt_eq    = r_eq;
        w_nxt_small = r_small;
        // A decided (non-equal) state is sticky; only an equal state looks
        // at the current slice.
        if (r_eq) begin
            w_nxt_big   = (w_slice_a > w_slice_b);
            w_nxt_small = (w_slice_a < w_slice_b);
            w_nxt_eq    = (w_slice_a == w_slice_b);
        end
    end

    assign w_finish = (r_idx == c_LAST) || ((EARLY_EXIT != 0) && !w_nxt_eq);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_idx      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_big      <= 1'b0;
            r_eq       <= 1'b1;
            r_small    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fo_big   <= 1'b0;
            r_fo_eq    <= 1'b1;
            r_fo_small <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        // Priority big > small > equal keeps the seed one-hot
                        // even for illegal cascade-in combinations.
                        r_big   <= fi_big;
                        r_small <= !fi_big && fi_small;
                        r_eq    <= !fi_big && !fi_small;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_big   <= w_nxt_big;
                    r_eq    <= w_nxt_eq;
                    r_small <= w_nxt_small;
                    r_a     <= r_a << SLICE_W;
                    r_b     <= r_b << SLICE_W;
                    r_idx   <= r_idx + c_ONE;
                    if (w_finish) begin
                        r_fo_big   <= w_nxt_big;
                        r_fo_eq    <= w_nxt_eq;
                        r_fo_small <= w_nxt_small;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign fo_big   = r_fo_big;
    assign fo_equal = r_fo_eq;
    assign fo_small = r_fo_small;

endmodule
`default_nettype wire
